// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 default timing for the VGA timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {PH_SYNC, PH_BP, PH_ACT, PH_FP} phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 11;

endpackage

// File: rtl/vga_axis_ctr.sv
// One timing axis: position counter, phase FSM, registered sync level and
// active-area coordinate, all advancing only when step is high.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0,
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] coord,
  output logic          sync,
  output logic          act_nxt,
  output logic          wrap
);

  localparam int TOTAL = SYNC + BP + ACTIVE + FP;
  localparam logic [CW-1:0] SYNC_END = CW'(SYNC - 1);
  localparam logic [CW-1:0] BP_END   = CW'(SYNC + BP - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(SYNC + BP + ACTIVE - 1);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_BASE = CW'(SYNC + BP);

  if (TOTAL > (2 ** CW) - 1 || ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0)
  begin : g_param_check
    $error("vga_axis_ctr: zero-width phase or total does not fit in CW bits");
  end

  phase_t        phase, phase_nxt;
  logic [CW-1:0] cnt_nxt, coord_nxt;
  logic          sync_nxt;

  assign wrap = step && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr) phase <= PH_SYNC;
    else     phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    if (step) begin
      unique case (phase)
        PH_SYNC: if (cnt == SYNC_END) phase_nxt = PH_BP;
        PH_BP:   if (cnt == BP_END)   phase_nxt = PH_ACT;
        PH_ACT:  if (cnt == ACT_END)  phase_nxt = PH_FP;
        PH_FP:   if (cnt == LAST)     phase_nxt = PH_SYNC;
        default: phase_nxt = PH_SYNC;
      endcase
    end
  end

  // Outputs are derived from next-state values so the registered copies
  // line up with the counter in the same cycle.
  always_comb begin
    cnt_nxt = cnt;
    if (step) cnt_nxt = wrap ? '0 : cnt + CW'(1);
    sync_nxt  = (phase_nxt == PH_SYNC) ? POL : !POL;
    act_nxt   = (phase_nxt == PH_ACT);
    coord_nxt = act_nxt ? cnt_nxt - ACT_BASE : '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt   <= '0;
      coord <= '0;
      sync  <= POL;
    end else begin
      cnt   <= cnt_nxt;
      coord <= coord_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters plus the
// registered vidon, line_start and frame_start outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          vidon,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          line_start,
  output logic          frame_start
);

  logic h_wrap, v_wrap, h_act_nxt, v_act_nxt;

  vga_axis_ctr #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CW(CW)
  ) u_h (
    .clk(clk), .clr(clr), .step(pix_en), .cnt(hc), .coord(px),
    .sync(hsync), .act_nxt(h_act_nxt), .wrap(h_wrap)
  );

  vga_axis_ctr #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CW(CW)
  ) u_v (
    .clk(clk), .clr(clr), .step(h_wrap), .cnt(vc), .coord(py),
    .sync(vsync), .act_nxt(v_act_nxt), .wrap(v_wrap)
  );

  // Strobes are set by the wrapping edge and cleared on the next clk,
  // independent of pix_en.
  always_ff @(posedge clk) begin
    if (clr) begin
      vidon       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vidon       <= h_act_nxt && v_act_nxt;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: small-mode randomized run against an
// arithmetic position model, plus a default-mode 640x480 sanity run.
module tb_vga_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr = 1'b1, pix_en = 1'b0;
  logic          hsync, vsync, vidon, line_start, frame_start;
  logic [CW-1:0] hc, vc, px, py;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CW(CW)
  ) dut (
    .clk(clk), .clr(clr), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .vidon(vidon), .hc(hc), .vc(vc), .px(px), .py(py),
    .line_start(line_start), .frame_start(frame_start)
  );

  logic          clr_b = 1'b1, en_b = 1'b0;
  logic          hsync_b, vsync_b, vidon_b, ls_b, fs_b;
  logic [CW-1:0] hc_b, vc_b, px_b, py_b;

  vga_timing_gen #(.H_POL(1'b1), .V_POL(1'b1)) dut_big (
    .clk(clk), .clr(clr_b), .pix_en(en_b), .hsync(hsync_b), .vsync(vsync_b),
    .vidon(vidon_b), .hc(hc_b), .vc(vc_b), .px(px_b), .py(py_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  typedef struct {
    int hc, vc, px, py;
    logic hsync, vsync, vidon, ls, fs;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   mh = 0, mv = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Position model: plain modular arithmetic; outputs follow from the
  // phase-width rules applied to the current position.
  task automatic applyStimulus(input logic c, input logic e);
    exp_t x;
    logic wrapped, hact, vact;
    clr = c;
    pix_en = e;
    wrapped = 1'b0;
    if (c) begin
      mh = 0;
      mv = 0;
    end else if (e) begin
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
        wrapped = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    hact    = (mh >= HS + HB) && (mh < HS + HB + HA);
    vact    = (mv >= VS + VB) && (mv < VS + VB + VA);
    x.hc    = mh;
    x.vc    = mv;
    x.px    = hact ? mh - (HS + HB) : 0;
    x.py    = vact ? mv - (VS + VB) : 0;
    x.hsync = (mh < HS) ? 1'b0 : 1'b1;
    x.vsync = (mv < VS) ? 1'b0 : 1'b1;
    x.vidon = hact && vact;
    x.ls    = wrapped;
    x.fs    = wrapped && (mv == 0);
    expq.push_back(x);
  endtask

  exp_t mon;
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        mon = expq.pop_front();
        checkOutput("hc", 32'(hc), mon.hc);
        checkOutput("vc", 32'(vc), mon.vc);
        checkOutput("px", 32'(px), mon.px);
        checkOutput("py", 32'(py), mon.py);
        checkOutput("hsync", 32'(hsync), 32'(mon.hsync));
        checkOutput("vsync", 32'(vsync), 32'(mon.vsync));
        checkOutput("vidon", 32'(vidon), 32'(mon.vidon));
        checkOutput("line_start", 32'(line_start), 32'(mon.ls));
        checkOutput("frame_start", 32'(frame_start), 32'(mon.fs));
      end
    end
  end

  initial begin
    int fs_count, hs_count, von_count, guard;

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);

    fs_count = 0;
    repeat (2 * HT * VT) begin
      applyStimulus(1'b0, 1'b1);
      if (frame_start === 1'b1) fs_count++;
    end
    checkOutput("frame_start_count", 32'(fs_count), 2);

    repeat (40) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
    end

    guard = 0;
    while (!(mh == 5 && mv == 3) && guard < 200) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    checkOutput("reach_hc5_vc3", 32'(guard < 200), 1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);

    repeat (2000)
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
    applyStimulus(1'b0, 1'b0);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(expq.size()), 0);

    checkOutput("big_reset_hsync", 32'(hsync_b), 1);
    checkOutput("big_reset_vsync", 32'(vsync_b), 1);
    clr_b = 1'b0;
    en_b  = 1'b1;
    hs_count  = 0;
    von_count = 0;
    repeat (36 * 800) begin
      @(posedge clk);
      #1;
      if (hsync_b === 1'b1) hs_count++;
      if (vidon_b === 1'b1) von_count++;
    end
    checkOutput("big_hsync_high", 32'(hs_count), 36 * 96);
    checkOutput("big_vidon_line35", 32'(von_count), 640);
    checkOutput("big_hc_end", 32'(hc_b), 0);
    checkOutput("big_vc_end", 32'(vc_b), 36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
